// File: rtl/rr_arbiter_lock_if.sv
// Request/grant bundle between the input-port VC request lines and the
// burst-lock round-robin arbiter. The arbiter sits on the slave side.
interface rr_arbiter_lock_if #(
   parameter int N_REQ   = 4,
   parameter int BURST_W = 3
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]   req_i;
   logic               update_i;
   logic               lock_i;
   logic [BURST_W-1:0] burst_max_i;
   logic [N_REQ-1:0]   grant_o;
   logic [IDX_W-1:0]   grant_idx_o;
   logic               locked_o;

   // Requester side: raises requests and consumes grants.
   modport master (
      output req_i, update_i, lock_i, burst_max_i,
      input  grant_o, grant_idx_o, locked_o
   );

   // Arbiter side.
   modport slave (
      input  req_i, update_i, lock_i, burst_max_i,
      output grant_o, grant_idx_o, locked_o
   );
endinterface

// File: rtl/rr_arbiter_lock.sv
// N-requester mask-based round-robin arbiter with a burst-lock mode: a
// granted requester can keep the grant for a programmable number of updates
// so a multi-flit packet crosses an output port atomically.
module rr_arbiter_lock #(
   parameter  int N_REQ   = 4,
   parameter  int BURST_W = 3,
   localparam int IDX_W   = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              arst,
   rr_arbiter_lock_if.slave  bus
);

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam logic [N_REQ-1:0] ONE_REQ = N_REQ'(1);

   // Isolates the lowest set bit of a request vector.
   function automatic logic [N_REQ-1:0] lowest_one(input logic [N_REQ-1:0] v);
      return v & (~v + ONE_REQ);
   endfunction

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   mask_q,  mask_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [BURST_W-1:0] cnt_q,   cnt_d;
   logic [BURST_W-1:0] max_q,   max_d;

   logic [N_REQ-1:0]   masked_req;
   logic [N_REQ-1:0]   rr_grant;
   logic               hold_lock;
   logic [N_REQ-1:0]   grant;
   logic [IDX_W-1:0]   grant_idx;
   logic [BURST_W-1:0] cnt_inc;

   // Grant selection: lock owner while it still requests, else mask-based RR
   // with a fall-back to raw priority once the mask has emptied.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      masked_req = bus.req_i & mask_q;
      rr_grant   = (masked_req != '0) ? lowest_one(masked_req) : lowest_one(bus.req_i);
      hold_lock  = (state_q == LOCKED) && bus.req_i[owner_q];
      grant      = '0;
      if (!arst) begin
         if (hold_lock) begin
            grant[owner_q] = 1'b1;
         end else begin
            grant = rr_grant;
         end
      end
   end

   // One-hot to binary for the grant index; zero when nothing is granted.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) grant_idx = IDX_W'(i);
      end
   end

   // Next-state: burst counting while the owner holds, RR mask advance and
   // lock entry otherwise. An owner that drops its request leaves the lock
   // with no bubble, and the same cycle cannot re-lock.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      cnt_inc = cnt_q + BURST_W'(1);
      if (hold_lock) begin
         if (bus.update_i) begin
            if (cnt_inc == max_q) begin
               state_d = ARB;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
      end else begin
         state_d = ARB;
         cnt_d   = '0;
         if (bus.update_i && (grant != '0)) begin
            for (int i = 0; i < N_REQ; i++) begin
               mask_d[i] = (IDX_W'(i) > grant_idx);
            end
            if ((state_q == ARB) && bus.lock_i && (bus.burst_max_i > BURST_W'(1))) begin
               state_d = LOCKED;
               owner_d = grant_idx;
               cnt_d   = BURST_W'(1);
               max_d   = bus.burst_max_i;
            end
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (arst) begin
         state_q <= ARB;
         mask_q  <= '1;
         owner_q <= '0;
         cnt_q   <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
      end
   end

   // Outputs are forced low while reset is asserted, since the reset only
   // takes effect at the next edge.
   always_comb begin
      bus.grant_o     = grant;
      bus.grant_idx_o = grant_idx;
      bus.locked_o    = (state_q == LOCKED) && !arst;
   end

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Bench for rr_arbiter_lock: directed scenarios plus random traffic, all
// checked against a pointer-based behavioural model of the arbiter.
module tb_rr_arbiter_lock;

   localparam int N_REQ   = 4;
   localparam int BURST_W = 3;

   logic clk;
   logic arst;

   rr_arbiter_lock_if #(.N_REQ(N_REQ), .BURST_W(BURST_W)) bus ();

   rr_arbiter_lock #(.N_REQ(N_REQ), .BURST_W(BURST_W)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: the next search starts at index ptr (ptr == N_REQ means only the
   // raw-priority fall-back applies); a lock holds an owner for rem more updates.
   int ptr      = 0;
   bit m_locked = 1'b0;
   int m_owner  = 0;
   int m_rem    = 0;

   int obs_idx;
   int obs_lock;
   int obs_grant;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_grant(input logic [N_REQ-1:0] req, input logic rst);
      if (rst) return -1;
      if (m_locked && req[m_owner]) return m_owner;
      for (int i = ptr; i < N_REQ; i++) if (req[i]) return i;
      for (int i = 0; i < N_REQ; i++) if (req[i]) return i;
      return -1;
   endfunction

   function automatic void model_step(input logic [N_REQ-1:0] req, input logic upd,
                                      input logic lk, input int bm, input logic rst,
                                      input int g);
      bit was_locked;
      if (rst) begin
         ptr      = 0;
         m_locked = 1'b0;
         return;
      end
      was_locked = m_locked;
      if (m_locked && req[m_owner]) begin
         if (upd) begin
            m_rem--;
            if (m_rem == 0) m_locked = 1'b0;
         end
      end else begin
         m_locked = 1'b0;
         if (upd && g >= 0) begin
            ptr = g + 1;
            if (!was_locked && lk && bm >= 2) begin
               m_locked = 1'b1;
               m_owner  = g;
               m_rem    = bm - 1;
            end
         end
      end
   endfunction

   // One clock: drive after the falling edge, check outputs, then let the
   // rising edge commit and advance the model.
   task automatic cycle(input logic [N_REQ-1:0] req, input logic upd, input logic lk,
                        input logic [BURST_W-1:0] bm, input logic rst);
      int g;
      int exp_grant;
      @(negedge clk);
      arst            = rst;
      bus.req_i       = req;
      bus.update_i    = upd;
      bus.lock_i      = lk;
      bus.burst_max_i = bm;
      #1;
      g         = model_grant(req, rst);
      exp_grant = (g < 0) ? 0 : (1 << g);
      obs_grant = int'(bus.grant_o);
      obs_idx   = int'(bus.grant_idx_o);
      obs_lock  = int'(bus.locked_o);
      check("grant",     obs_grant, exp_grant);
      check("grant_idx", obs_idx,   (g < 0) ? 0 : g);
      check("locked",    obs_lock,  (m_locked && !rst) ? 1 : 0);
      @(posedge clk);
      model_step(req, upd, lk, int'(bm), rst, g);
   endtask

   int exp_seq[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      arst            = 1'b1;
      bus.req_i       = '0;
      bus.update_i    = 1'b0;
      bus.lock_i      = 1'b0;
      bus.burst_max_i = '0;

      // Plain rotation with wrap after the top requester.
      cycle(4'b0000, 1'b0, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
         check("rotate_seq", obs_idx, exp_seq[i]);
      end

      // Raw fall-back: last grant 1, only requesters 0/1 pending.
      cycle(4'b0000, 1'b0, 1'b0, 3'd0, 1'b1);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      cycle(4'b0011, 1'b1, 1'b0, 3'd0, 1'b0);
      check("raw_fallback", obs_grant, 1);
      cycle(4'b0011, 1'b0, 1'b0, 3'd0, 1'b0);
      check("mask_after_fallback", obs_idx, 1);

      // Burst of 3 on requester 0.
      cycle(4'b0000, 1'b0, 1'b0, 3'd0, 1'b1);
      cycle(4'b1111, 1'b1, 1'b1, 3'd3, 1'b0);
      check("burst_entry_idx", obs_idx, 0);
      cycle(4'b1111, 1'b1, 1'b1, 3'd3, 1'b0);
      check("burst_hold1", obs_idx, 0);
      check("burst_locked1", obs_lock, 1);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      check("burst_hold2", obs_idx, 0);
      check("burst_locked2", obs_lock, 1);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      check("burst_after_idx", obs_idx, 1);
      check("burst_after_lock", obs_lock, 0);

      // Owner 2 drops mid-burst: same-cycle handover to 3.
      cycle(4'b0000, 1'b0, 1'b0, 3'd0, 1'b1);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      cycle(4'b1111, 1'b1, 1'b1, 3'd5, 1'b0);
      check("lock_owner2", obs_idx, 2);
      cycle(4'b1011, 1'b1, 1'b1, 3'd5, 1'b0);
      check("drop_handover", obs_idx, 3);
      check("drop_still_locked", obs_lock, 1);
      cycle(4'b1111, 1'b0, 1'b0, 3'd0, 1'b0);
      check("drop_unlocked", obs_lock, 0);

      // Burst length 0 or 1 never locks.
      cycle(4'b0000, 1'b0, 1'b0, 3'd0, 1'b1);
      cycle(4'b1111, 1'b1, 1'b1, 3'd1, 1'b0);
      cycle(4'b1111, 1'b1, 1'b1, 3'd0, 1'b0);
      check("short_burst_lock", obs_lock, 0);
      check("short_burst_idx", obs_idx, 1);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      check("short_burst_next", obs_idx, 2);

      // Reset during a burst.
      cycle(4'b1111, 1'b1, 1'b1, 3'd7, 1'b0);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      check("pre_reset_locked", obs_lock, 1);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b1);
      check("reset_grant", obs_grant, 0);
      check("reset_locked", obs_lock, 0);
      cycle(4'b1111, 1'b0, 1'b0, 3'd0, 1'b0);
      check("post_reset_idx", obs_idx, 0);
      check("post_reset_lock", obs_lock, 0);

      // Update with no request changes nothing.
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b1, 3'd4, 1'b0);
      check("idle_grant", obs_grant, 0);
      check("idle_idx", obs_idx, 0);
      cycle(4'b1111, 1'b1, 1'b0, 3'd0, 1'b0);
      check("idle_no_advance", obs_idx, 1);

      // Random traffic; owners mostly keep requesting so bursts run out.
      for (int i = 0; i < 1500; i++) begin
         logic [N_REQ-1:0] r;
         r = N_REQ'($urandom_range(0, 15));
         if (m_locked && $urandom_range(0, 9) < 8) r[m_owner] = 1'b1;
         cycle(r,
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 3),
               BURST_W'($urandom_range(0, 7)),
               ($urandom_range(0, 99) < 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
